// File: rtl/definitions.sv
// definitions: shared opcode enum, instruction word width and loader state type
package definitions;
    localparam int INSTR_W = 9;

    typedef enum logic [3:0] {
        LW, SW, ASSIGN, CLRSC, MOV, JMP, DONE, ADD,
        SUB, BEQ, AND, OR, BGE, BNE, SL, SR
    } op_t;

    typedef enum logic [1:0] {IDLE, LOAD, FINISH, ERROR} ld_state_t;

    function automatic logic op_has_mode(op_t op);
        return op inside {MOV, ADD, SUB, BEQ, AND, OR, BGE, BNE};
    endfunction
endpackage

// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: valid/ready stream carrying symbolic instruction fields
interface instr_encoder_loader_if;
    logic              in_valid;
    logic              in_ready;
    definitions::op_t  in_op;
    logic              in_mode;
    logic [3:0]        in_operand;

    modport master(output in_valid, in_op, in_mode, in_operand, input in_ready);
    modport slave(input in_valid, in_op, in_mode, in_operand, output in_ready);
endinterface

// File: rtl/instr_pack.sv
// instr_pack: combinational packer from instruction fields to the 9-bit machine word
module instr_pack
    import definitions::*;
(
    input  op_t                op,
    input  logic               mode,
    input  logic [3:0]         operand,
    output logic [INSTR_W-1:0] word
);
    // CLRSC and DONE carry no field; zero it so stray inputs never reach memory
    always_comb word = (op == CLRSC || op == DONE) ? {op, 5'b0} : {op, mode, operand};
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs streamed instruction fields and writes them to
// consecutive instruction-memory addresses, tracking length and XOR checksum.
module instr_encoder_loader
    import definitions::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    start,
    instr_encoder_loader_if.slave   bus,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [INSTR_W-1:0]      wr_data,
    output logic                    busy,
    output logic                    load_done,
    output logic                    err_ovf,
    output logic [ADDR_W:0]         prog_len,
    output logic [INSTR_W-1:0]      checksum
);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

    ld_state_t          state, state_nx;
    logic               fire, full, restart, ovf;
    logic [INSTR_W-1:0] word;

    instr_pack u_pack (
        .op      (bus.in_op),
        .mode    (bus.in_mode),
        .operand (bus.in_operand),
        .word    (word)
    );

    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    if (ovf) state_nx = ERROR;
                     else if (fire && bus.in_op == DONE) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            ERROR:   if (start) state_nx = LOAD;
            default: state_nx = IDLE;
        endcase
    end

    // in_ready looks only at state and length, never at in_valid
    always_comb begin
        full         = prog_len == LIMIT;
        bus.in_ready = state == LOAD && !full;
        busy         = state == LOAD || state == FINISH;
        fire         = bus.in_valid && bus.in_ready;
        ovf          = state == LOAD && bus.in_valid && full;
        restart      = start && (state == IDLE || state == ERROR);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_en     <= 1'b0;
            wr_addr   <= ADDR_W'(BASE_ADDR);
            wr_data   <= '0;
            load_done <= 1'b0;
            err_ovf   <= 1'b0;
            prog_len  <= '0;
            checksum  <= '0;
        end else begin
            wr_en <= fire;
            if (restart) begin
                prog_len  <= '0;
                checksum  <= '0;
                load_done <= 1'b0;
                err_ovf   <= 1'b0;
            end
            if (fire) begin
                wr_addr  <= ADDR_W'(BASE_ADDR) + prog_len[ADDR_W-1:0];
                wr_data  <= word;
                prog_len <= prog_len + 1'b1;
                checksum <= checksum ^ word;
                if (bus.in_op == DONE) load_done <= 1'b1;
            end
            if (ovf) err_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: table-driven checks of packing, write sequencing,
// DONE/overflow termination and reset behaviour of instr_encoder_loader.
module tb_instr_encoder_loader;
    import definitions::*;

    typedef struct {
        op_t        op;
        logic       mode;
        logic [3:0] operand;
        logic [8:0] exp;
    } vec_t;

    logic Clk, Reset_n, start, start4;
    logic wr_en, busy, load_done, err_ovf, wr_en4, busy4, load_done4, err_ovf4;
    logic [9:0]  wr_addr, wr_addr4;
    logic [8:0]  wr_data, checksum, wr_data4, checksum4;
    logic [10:0] prog_len, prog_len4;
    int n_chk, n_fail;
    vec_t vecs[8];
    vec_t ovf[5];
    logic [8:0] acc;

    instr_encoder_loader_if b();
    instr_encoder_loader_if b4();

    instr_encoder_loader dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .bus(b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .load_done(load_done), .err_ovf(err_ovf), .prog_len(prog_len), .checksum(checksum)
    );

    instr_encoder_loader #(.DEPTH(4)) dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .start(start4), .bus(b4),
        .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4), .busy(busy4),
        .load_done(load_done4), .err_ovf(err_ovf4), .prog_len(prog_len4), .checksum(checksum4)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        Reset_n = 1'b0;
        start = 1'b0;
        start4 = 1'b0;
        b.in_valid = 1'b0; b.in_op = LW; b.in_mode = 1'b0; b.in_operand = 4'h0;
        b4.in_valid = 1'b0; b4.in_op = LW; b4.in_mode = 1'b0; b4.in_operand = 4'h0;

        vecs[0] = '{ADD,   1'b1, 4'h3, 9'b0111_1_0011};
        vecs[1] = '{SUB,   1'b0, 4'hA, 9'b1000_0_1010};
        vecs[2] = '{CLRSC, 1'b1, 4'hF, 9'b0011_0_0000};
        vecs[3] = '{LW,    1'b1, 4'h5, 9'b0000_1_0101};
        vecs[4] = '{SR,    1'b0, 4'h7, 9'b1111_0_0111};
        vecs[5] = '{MOV,   1'b1, 4'hC, 9'b0100_1_1100};
        vecs[6] = '{BNE,   1'b1, 4'h1, 9'b1101_1_0001};
        vecs[7] = '{DONE,  1'b1, 4'h9, 9'b0110_0_0000};

        ovf[0] = '{SW,  1'b0, 4'h1, 9'b0001_0_0001};
        ovf[1] = '{OR,  1'b1, 4'h2, 9'b1011_1_0010};
        ovf[2] = '{SL,  1'b0, 4'h3, 9'b1110_0_0011};
        ovf[3] = '{BGE, 1'b1, 4'h4, 9'b1100_1_0100};
        ovf[4] = '{ADD, 1'b1, 4'h5, 9'b0111_1_0101};

        repeat (2) @(negedge Clk);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_load_done", 32'(load_done), 0);
        chk("rst_err_ovf", 32'(err_ovf), 0);
        chk("rst_prog_len", 32'(prog_len), 0);
        chk("rst_checksum", 32'(checksum), 0);
        chk("rst_in_ready", 32'(b.in_ready), 0);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("idle_in_ready", 32'(b.in_ready), 0);

        // main table: back-to-back bundles ending in DONE
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        chk("load_busy", 32'(busy), 1);
        chk("load_in_ready", 32'(b.in_ready), 1);
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            b.in_valid = 1'b1;
            b.in_op = vecs[i].op;
            b.in_mode = vecs[i].mode;
            b.in_operand = vecs[i].operand;
            @(negedge Clk);
            acc = acc ^ vecs[i].exp;
            chk($sformatf("vec%0d_wr_en", i), 32'(wr_en), 1);
            chk($sformatf("vec%0d_wr_addr", i), 32'(wr_addr), 32'(i));
            chk($sformatf("vec%0d_wr_data", i), 32'(wr_data), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_prog_len", i), 32'(prog_len), 32'(i + 1));
            chk($sformatf("vec%0d_checksum", i), 32'(checksum), 32'(acc));
        end
        b.in_valid = 1'b0;
        chk("done_load_done", 32'(load_done), 1);
        @(negedge Clk);
        chk("after_done_wr_en", 32'(wr_en), 0);
        chk("after_done_busy", 32'(busy), 0);
        chk("after_done_in_ready", 32'(b.in_ready), 0);
        chk("after_done_prog_len", 32'(prog_len), 8);
        chk("after_done_checksum", 32'(checksum), 32'(acc));
        chk("after_done_load_done", 32'(load_done), 1);

        // start and valid together in IDLE: accepted one cycle later
        b.in_op = AND; b.in_mode = 1'b0; b.in_operand = 4'h6;
        b.in_valid = 1'b1;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        chk("sv_no_write", 32'(wr_en), 0);
        chk("sv_prog_len_clr", 32'(prog_len), 0);
        chk("sv_checksum_clr", 32'(checksum), 0);
        chk("sv_load_done_clr", 32'(load_done), 0);
        chk("sv_in_ready", 32'(b.in_ready), 1);
        @(negedge Clk);
        b.in_valid = 1'b0;
        chk("sv_wr_en", 32'(wr_en), 1);
        chk("sv_wr_addr", 32'(wr_addr), 0);
        chk("sv_wr_data", 32'(wr_data), 32'(9'b1010_0_0110));
        chk("sv_prog_len", 32'(prog_len), 1);

        // reset right after a handshake drops the pending write
        b.in_op = JMP; b.in_mode = 1'b1; b.in_operand = 4'h2;
        b.in_valid = 1'b1;
        @(posedge Clk);
        #1;
        chk("pre_rst_wr_en", 32'(wr_en), 1);
        chk("pre_rst_wr_addr", 32'(wr_addr), 1);
        Reset_n = 1'b0;
        b.in_valid = 1'b0;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 0);
        chk("mid_rst_wr_addr", 32'(wr_addr), 0);
        chk("mid_rst_wr_data", 32'(wr_data), 0);
        chk("mid_rst_prog_len", 32'(prog_len), 0);
        chk("mid_rst_checksum", 32'(checksum), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        @(negedge Clk);
        chk("mid_rst_wr_en_hold", 32'(wr_en), 0);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("post_rst_in_ready", 32'(b.in_ready), 0);

        // DEPTH=4 instance: fifth bundle overflows
        start4 = 1'b1;
        @(negedge Clk);
        start4 = 1'b0;
        acc = '0;
        for (int k = 0; k < 5; k++) begin
            b4.in_valid = 1'b1;
            b4.in_op = ovf[k].op;
            b4.in_mode = ovf[k].mode;
            b4.in_operand = ovf[k].operand;
            chk($sformatf("ovf%0d_in_ready", k), 32'(b4.in_ready), (k < 4) ? 1 : 0);
            @(negedge Clk);
            if (k < 4) begin
                acc = acc ^ ovf[k].exp;
                chk($sformatf("ovf%0d_wr_en", k), 32'(wr_en4), 1);
                chk($sformatf("ovf%0d_wr_addr", k), 32'(wr_addr4), 32'(k));
                chk($sformatf("ovf%0d_wr_data", k), 32'(wr_data4), 32'(ovf[k].exp));
                chk($sformatf("ovf%0d_prog_len", k), 32'(prog_len4), 32'(k + 1));
            end else begin
                chk("ovf_no_write", 32'(wr_en4), 0);
                chk("ovf_err", 32'(err_ovf4), 1);
                chk("ovf_prog_len", 32'(prog_len4), 4);
                chk("ovf_checksum", 32'(checksum4), 32'(acc));
                chk("ovf_busy", 32'(busy4), 0);
                chk("ovf_in_ready", 32'(b4.in_ready), 0);
            end
        end
        b4.in_valid = 1'b0;
        @(negedge Clk);
        chk("err_hold", 32'(err_ovf4), 1);
        chk("err_in_ready", 32'(b4.in_ready), 0);
        chk("err_wr_en", 32'(wr_en4), 0);
        start4 = 1'b1;
        @(negedge Clk);
        start4 = 1'b0;
        chk("restart_err_clr", 32'(err_ovf4), 0);
        chk("restart_prog_len", 32'(prog_len4), 0);
        chk("restart_checksum", 32'(checksum4), 0);
        chk("restart_in_ready", 32'(b4.in_ready), 1);
        chk("restart_busy", 32'(busy4), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
